// File: rtl/pkt_bus_pkg.sv
// rtl/pkt_bus_pkg.sv - flit framing constants and receive FSM states
package pkt_bus_pkg;
   localparam int FLIT_W = 134;
   localparam logic [1:0] TAG_HEAD = 2'b01;
   localparam logic [1:0] TAG_BODY = 2'b11;
   localparam int TAG_HI = 133;
   localparam int TAG_LO = 132;
   localparam int BINFO_HI = 131;
   localparam int BINFO_LO = 128;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RECV = 2'd1,
      ST_DROP = 2'd2
   } rx_state_t;
endpackage

// File: rtl/ram_sdp.sv
// rtl/ram_sdp.sv - simple dual-port RAM, one write port, registered read port
module ram_sdp #(
   parameter int AW = 7,
   parameter int DW = 134
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);
   logic [DW-1:0] mem [0:(1<<AW)-1];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      rdata <= mem[raddr];
   end
endmodule

// File: rtl/pkt_rx_buffer.sv
// rtl/pkt_rx_buffer.sv - store-and-forward packet buffer with commit/rollback
module pkt_rx_buffer
   import pkt_bus_pkg::*;
#(
   parameter int DATA_AW    = 7,
   parameter int DESC_AW    = 4,
   parameter int ALF_MARGIN = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_data_wr,
   input  logic [FLIT_W-1:0] in_data,
   input  logic              in_data_valid_wr,
   input  logic              in_data_valid,
   output logic              in_ready,
   output logic              out_data_wr,
   output logic [FLIT_W-1:0] out_data,
   output logic              out_data_valid,
   output logic              out_data_valid_wr,
   input  logic              out_ready,
   output logic [31:0]       pkt_in_cnt,
   output logic [31:0]       pkt_out_cnt,
   output logic [31:0]       drop_cnt
);
   localparam logic [DATA_AW:0] DEPTH      = {1'b1, {DATA_AW{1'b0}}};
   localparam logic [DATA_AW:0] PTR_ONE    = {{DATA_AW{1'b0}}, 1'b1};
   localparam logic [DATA_AW:0] ALF        = ALF_MARGIN[DATA_AW:0];
   localparam logic [DESC_AW:0] DESC_DEPTH = {1'b1, {DESC_AW{1'b0}}};

   typedef struct packed {
      logic [DATA_AW:0] start;
      logic [DATA_AW:0] len;
   } desc_t;

   rx_state_t state, state_n;
   logic [DATA_AW:0] wr_ptr, wr_ptr_n, commit_ptr, commit_ptr_n, start_ptr, start_ptr_n;
   logic [DATA_AW:0] rd_free, used, free;
   logic             buf_full, full_at_commit, is_head;
   logic             ram_we, desc_push, in_inc;
   logic [1:0]       drop_inc;
   logic [DATA_AW-1:0] ram_waddr, ram_raddr;
   logic [FLIT_W-1:0]  ram_rdata;

   desc_t            desc_mem [0:(1<<DESC_AW)-1];
   desc_t            desc_head;
   logic [DESC_AW:0] desc_wp, desc_rp, desc_cnt;
   logic             desc_full;

   logic             tx_active, tx_start, rd_issue, rd_last;
   logic [DATA_AW:0] tx_ptr, tx_left, tx_end;

   // Occupancy counts everything from the oldest unsent flit to the open write pointer.
   assign used           = wr_ptr - rd_free;
   assign free           = DEPTH - used;
   assign buf_full       = (used == DEPTH);
   assign full_at_commit = ((commit_ptr - rd_free) == DEPTH);
   assign is_head        = (in_data[TAG_HI:TAG_LO] == TAG_HEAD);
   assign desc_cnt       = desc_wp - desc_rp;
   assign desc_full      = (desc_cnt == DESC_DEPTH);
   assign desc_head      = desc_mem[desc_rp[DESC_AW-1:0]];

   always_comb begin
      state_n      = state;
      wr_ptr_n     = wr_ptr;
      commit_ptr_n = commit_ptr;
      start_ptr_n  = start_ptr;
      ram_we       = 1'b0;
      ram_waddr    = wr_ptr[DATA_AW-1:0];
      desc_push    = 1'b0;
      in_inc       = 1'b0;
      drop_inc     = 2'd0;
      if (state != ST_DROP && in_data_wr) begin
         if (is_head) begin
            // A head always restarts from the committed point, aborting any open packet.
            if (state == ST_RECV) drop_inc = 2'd1;
            wr_ptr_n = commit_ptr;
            if (full_at_commit) begin
               state_n = ST_DROP;
            end else begin
               ram_we      = 1'b1;
               ram_waddr   = commit_ptr[DATA_AW-1:0];
               start_ptr_n = commit_ptr;
               wr_ptr_n    = commit_ptr + PTR_ONE;
               state_n     = ST_RECV;
            end
         end else if (state == ST_RECV) begin
            if (buf_full) begin
               state_n = ST_DROP;
            end else begin
               ram_we   = 1'b1;
               wr_ptr_n = wr_ptr + PTR_ONE;
            end
         end else begin
            drop_inc = 2'd1;
         end
      end
      if (in_data_valid_wr && state_n != ST_IDLE) begin
         if (state_n == ST_RECV && in_data_valid && !desc_full) begin
            commit_ptr_n = wr_ptr_n;
            desc_push    = 1'b1;
            in_inc       = 1'b1;
         end else begin
            wr_ptr_n = commit_ptr;
            drop_inc = drop_inc + 2'd1;
         end
         state_n = ST_IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         wr_ptr     <= '0;
         commit_ptr <= '0;
         start_ptr  <= '0;
         desc_wp    <= '0;
         pkt_in_cnt <= '0;
         drop_cnt   <= '0;
         in_ready   <= 1'b0;
      end else begin
         state      <= state_n;
         wr_ptr     <= wr_ptr_n;
         commit_ptr <= commit_ptr_n;
         start_ptr  <= start_ptr_n;
         desc_wp    <= desc_wp + {{DESC_AW{1'b0}}, desc_push};
         pkt_in_cnt <= pkt_in_cnt + {31'b0, in_inc};
         drop_cnt   <= drop_cnt + {30'b0, drop_inc};
         in_ready   <= (free >= ALF) && !desc_full;
      end
   end

   always_ff @(posedge clk) begin
      if (desc_push) desc_mem[desc_wp[DESC_AW-1:0]] <= '{start: start_ptr_n, len: wr_ptr_n - start_ptr_n};
   end

   assign tx_start  = !tx_active && (desc_cnt != '0) && out_ready;
   assign rd_issue  = tx_start || tx_active;
   assign rd_last   = tx_start ? (desc_head.len == PTR_ONE) : (tx_left == PTR_ONE);
   assign ram_raddr = tx_start ? desc_head.start[DATA_AW-1:0] : tx_ptr[DATA_AW-1:0];

   // Space is released only when the last flit leaves, so tx_end must survive one extra cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_active         <= 1'b0;
         tx_ptr            <= '0;
         tx_left           <= '0;
         tx_end            <= '0;
         desc_rp           <= '0;
         rd_free           <= '0;
         out_data_wr       <= 1'b0;
         out_data_valid_wr <= 1'b0;
         out_data_valid    <= 1'b0;
         pkt_out_cnt       <= '0;
      end else begin
         if (tx_start) begin
            desc_rp   <= desc_rp + {{DESC_AW{1'b0}}, 1'b1};
            tx_ptr    <= desc_head.start + PTR_ONE;
            tx_left   <= desc_head.len - PTR_ONE;
            tx_active <= (desc_head.len != PTR_ONE);
            tx_end    <= desc_head.start + desc_head.len;
         end else if (tx_active) begin
            tx_ptr  <= tx_ptr + PTR_ONE;
            tx_left <= tx_left - PTR_ONE;
            if (tx_left == PTR_ONE) tx_active <= 1'b0;
         end
         out_data_wr       <= rd_issue;
         out_data_valid_wr <= rd_issue && rd_last;
         out_data_valid    <= rd_issue && rd_last;
         if (out_data_wr && out_data_valid_wr) begin
            rd_free     <= tx_end;
            pkt_out_cnt <= pkt_out_cnt + 32'd1;
         end
      end
   end

   assign out_data = out_data_wr ? ram_rdata : '0;

   ram_sdp #(.AW(DATA_AW), .DW(FLIT_W)) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (ram_waddr),
      .wdata (in_data),
      .raddr (ram_raddr),
      .rdata (ram_rdata)
   );
endmodule

// File: tb/tb_pkt_rx_buffer.sv
// tb/tb_pkt_rx_buffer.sv - scoreboard bench for pkt_rx_buffer
module tb_pkt_rx_buffer;
   import pkt_bus_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic              in_data_wr = 1'b0, in_data_valid_wr = 1'b0, in_data_valid = 1'b0;
   logic [FLIT_W-1:0] in_data = '0;
   logic              out_ready = 1'b1;
   logic              in_ready, out_data_wr, out_data_valid, out_data_valid_wr;
   logic [FLIT_W-1:0] out_data;
   logic [31:0]       pkt_in_cnt, pkt_out_cnt, drop_cnt;

   pkt_rx_buffer dut (
      .clk(clk), .rst(rst),
      .in_data_wr(in_data_wr), .in_data(in_data),
      .in_data_valid_wr(in_data_valid_wr), .in_data_valid(in_data_valid),
      .in_ready(in_ready),
      .out_data_wr(out_data_wr), .out_data(out_data),
      .out_data_valid(out_data_valid), .out_data_valid_wr(out_data_valid_wr),
      .out_ready(out_ready),
      .pkt_in_cnt(pkt_in_cnt), .pkt_out_cnt(pkt_out_cnt), .drop_cnt(drop_cnt)
   );

   typedef struct packed {
      logic [FLIT_W-1:0] data;
      logic              last;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   out_seen = 0;
   bit   arm_first = 1'b0;
   int   first_cyc = 0;
   int   last_cyc = 0;
   int   commit_cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!rst && out_data_wr) begin
         out_seen++;
         last_cyc = cyc;
         if (arm_first) begin
            first_cyc = cyc;
            arm_first = 1'b0;
         end
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_flit got %h exp none", out_data);
         end else begin
            mon_e = exp_q.pop_front();
            if (out_data !== mon_e.data) begin
               errors++;
               $display("FAIL flit_data got %h exp %h", out_data, mon_e.data);
            end
            checks++;
            if ({out_data_valid_wr, out_data_valid} !== {mon_e.last, mon_e.last}) begin
               errors++;
               $display("FAIL flit_eop got %b%b exp %b%b", out_data_valid_wr, out_data_valid,
                        mon_e.last, mon_e.last);
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d exp %0d", name, got, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         in_data_wr = 1'b0; in_data_valid_wr = 1'b0; in_data_valid = 1'b0; in_data = '0;
      end
   endtask

   task automatic drive(input logic [FLIT_W-1:0] d, input logic vwr, input logic v, input logic expect_out);
      exp_t e;
      @(negedge clk);
      in_data_wr = 1'b1; in_data = d; in_data_valid_wr = vwr; in_data_valid = v;
      if (vwr) commit_cyc = cyc;
      if (expect_out) begin
         e.data = d;
         e.last = vwr;
         exp_q.push_back(e);
      end
   endtask

   // keep: end with valid=1; term: send the end-of-packet strobe on the last flit
   task automatic send_pkt(input logic [31:0] id, input int n, input logic keep, input logic term,
                           input logic expect_out);
      logic [1:0]        tag;
      logic [FLIT_W-1:0] d;
      logic              lst;
      for (int i = 0; i < n; i++) begin
         tag = (i == 0) ? TAG_HEAD : TAG_BODY;
         lst = term && (i == n - 1);
         d   = {tag, 4'hf, id, 32'(i), 64'hA5A5_5A5A_0F0F_F0F0};
         drive(d, lst, lst && keep, expect_out && keep && term);
      end
      idle(1);
   endtask

   task automatic wait_drain(input string name, input int budget);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_drain got %0d left exp 0", name, exp_q.size());
         exp_q.delete();
      end
      idle(3);
   endtask

   initial begin
      logic [FLIT_W-1:0] d;
      int seen0;

      repeat (3) @(negedge clk);
      check("rst_out_wr", {31'b0, out_data_wr}, 0);
      check("rst_in_ready", {31'b0, in_ready}, 0);
      check("rst_cnts", pkt_in_cnt | pkt_out_cnt | drop_cnt, 0);
      rst = 1'b0;
      @(posedge clk); #1;
      check("rel_in_ready", {31'b0, in_ready}, 1);

      // 9-flit packet with fixed head and tail payloads
      arm_first = 1'b1;
      for (int i = 0; i < 9; i++) begin
         if (i == 0)      d = {TAG_HEAD, 4'hf, 128'h1111_1111_1111_1111_1111_1111_0800_4500};
         else if (i == 8) d = {TAG_BODY, 4'h2, 128'h2233};
         else             d = {TAG_BODY, 4'hf, 96'h0, 32'(i)};
         drive(d, i == 8, i == 8, 1'b1);
      end
      idle(1);
      wait_drain("pkt9", 100);
      check("pkt9_latency", 32'(first_cyc - commit_cyc), 2);
      check("pkt9_in_cnt", pkt_in_cnt, 1);
      check("pkt9_out_cnt", pkt_out_cnt, 1);

      // 8-flit packet discarded by valid=0
      seen0 = out_seen;
      send_pkt(32'h200, 8, 1'b0, 1'b1, 1'b0);
      idle(10);
      check("disc_out_seen", 32'(out_seen - seen0), 0);
      check("disc_drop_cnt", drop_cnt, 1);
      check("disc_in_ready", {31'b0, in_ready}, 1);

      // head after 3 flits aborts the open packet
      send_pkt(32'h300, 3, 1'b1, 1'b0, 1'b1);
      send_pkt(32'h301, 4, 1'b1, 1'b1, 1'b1);
      wait_drain("abort", 100);
      check("abort_drop_cnt", drop_cnt, 2);
      check("abort_in_cnt", pkt_in_cnt, 2);
      check("abort_out_cnt", pkt_out_cnt, 2);

      // fill the buffer with out_ready low, then release
      out_ready = 1'b0;
      seen0 = out_seen;
      for (int p = 0; p < 8; p++) begin
         idle(2);
         check("fill_in_ready_pre", {31'b0, in_ready}, 1);
         send_pkt(32'h400 + 32'(p), 16, 1'b1, 1'b1, 1'b1);
      end
      idle(4);
      check("fill_in_ready_full", {31'b0, in_ready}, 0);
      check("fill_held", 32'(out_seen - seen0), 0);
      check("fill_in_cnt", pkt_in_cnt, 10);
      arm_first = 1'b1;
      @(negedge clk);
      out_ready = 1'b1;
      wait_drain("fill", 400);
      check("fill_out_seen", 32'(out_seen - seen0), 128);
      checks++;
      if (last_cyc - first_cyc > 134) begin
         errors++;
         $display("FAIL fill_span got %0d exp <=134", last_cyc - first_cyc);
      end
      check("fill_out_cnt", pkt_out_cnt, 10);
      check("fill_in_ready_back", {31'b0, in_ready}, 1);

      // reset during flit 4 with one committed packet still buffered
      out_ready = 1'b0;
      seen0 = out_seen;
      send_pkt(32'h500, 2, 1'b1, 1'b1, 1'b0);
      send_pkt(32'h501, 3, 1'b1, 1'b0, 1'b0);
      drive({TAG_BODY, 4'hf, 128'h4}, 1'b0, 1'b0, 1'b0);
      rst = 1'b1;
      idle(2);
      check("mid_rst_out", {31'b0, out_data_wr | out_data_valid | out_data_valid_wr}, 0);
      check("mid_rst_data_zero", {31'b0, out_data == '0}, 1);
      check("mid_rst_cnts", pkt_in_cnt | pkt_out_cnt | drop_cnt, 0);
      check("mid_rst_in_ready", {31'b0, in_ready}, 0);
      rst = 1'b0;
      @(posedge clk); #1;
      check("mid_rel_in_ready", {31'b0, in_ready}, 1);
      @(negedge clk);
      out_ready = 1'b1;
      idle(10);
      check("mid_rst_no_output", 32'(out_seen - seen0), 0);

      // stray body flit in idle, then a 2-flit packet
      drive({TAG_BODY, 4'hf, 128'hdead}, 1'b0, 1'b0, 1'b0);
      idle(1);
      send_pkt(32'h600, 2, 1'b1, 1'b1, 1'b1);
      wait_drain("stray", 100);
      check("stray_drop_cnt", drop_cnt, 1);
      check("stray_in_cnt", pkt_in_cnt, 1);
      check("stray_out_cnt", pkt_out_cnt, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
